set_driver: RTL and testbench

SET_DRIVER -- requirements
Module: set_driver

---
 rtl/set_pkg.sv | 27 ++
 rtl/set_drv_wdog.sv | 26 ++
 rtl/set_driver.sv | 182 ++++++++++++++++++
 tb/tb_set_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// set_pkg: shared constants and FSM state type for the SET pattern driver.
package set_pkg;
  localparam int COORD_W = 4;
  localparam int CAND_W  = 8;
  localparam int CENT_W  = 6 * COORD_W;
  localparam int RAD_W   = 3 * COORD_W;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_UNION  = 2'b01;
  localparam logic [1:0] MODE_DIFF   = 2'b10;
  localparam logic [1:0] MODE_INTER  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_BUSY,
    ST_ISSUE,
    ST_WAIT_VALID,
    ST_CHECK,
    ST_DONE
  } drv_state_t;

  // Error counter increment that sticks at all-ones.
  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7F) ? v : v + 7'd1;
  endfunction
endpackage

// File: rtl/set_drv_wdog.sv
// set_drv_wdog: per-pattern watchdog counter for set_driver.
// Only instantiated when SET_DRV_TIMEOUT_EN is defined.
module set_drv_wdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_cnt_en,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expired;

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYC));
  assign o_expired = w_expired;

  // Count waiting cycles; hold at the limit so the expiry stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_cnt_en && !w_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/set_driver.sv
// set_driver: walks a pattern ROM, issues each pattern to the SET engine,
// compares the returned candidate count against the expected value and
// reports done/pass/err_cnt/fail_idx.
// Optional feature: define SET_DRV_TIMEOUT_EN to add a per-pattern watchdog
// (TIMEOUT_CYC cycles) that turns a stuck pattern into a mismatch.
module set_driver
  import set_pkg::*;
#(
  parameter int NUM_PAT     = 64,
  parameter int ERR_LIMIT   = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode_cfg,
  output logic [5:0]        pat_addr,
  input  logic [CENT_W-1:0] pat_central,
  input  logic [RAD_W-1:0]  pat_radius,
  input  logic [CAND_W-1:0] exp_cand,
  output logic              en,
  output logic [CENT_W-1:0] central,
  output logic [RAD_W-1:0]  radius,
  output logic [1:0]        mode,
  input  logic              busy,
  input  logic              valid,
  input  logic [CAND_W-1:0] candidate,
  output logic              done,
  output logic              pass,
  output logic [6:0]        err_cnt,
  output logic [5:0]        fail_idx
);
  localparam logic [5:0] LAST_IDX = 6'(NUM_PAT - 1);
  localparam logic [6:0] ERR_LIM  = 7'(ERR_LIMIT);

  drv_state_t        r_state;
  logic              r_fetch_ph;   // 0: address out, 1: ROM data valid
  logic [5:0]        r_idx;
  logic [5:0]        r_addr;
  logic [CENT_W-1:0] r_pat_c;
  logic [RAD_W-1:0]  r_pat_r;
  logic [CAND_W-1:0] r_exp;
  logic [CAND_W-1:0] r_cand;
  logic              r_tmo_hit;
  logic              r_en;
  logic [CENT_W-1:0] r_central;
  logic [RAD_W-1:0]  r_radius;
  logic [1:0]        r_mode;
  logic              r_done;
  logic              r_pass;
  logic [6:0]        r_err;
  logic [5:0]        r_fidx;

  logic              w_tmo;
  logic              w_mismatch;
  logic [6:0]        w_err_nxt;
  logic              w_stop;

`ifdef SET_DRV_TIMEOUT_EN
  logic w_wd_clr;
  logic w_wd_cnt;
  // FETCH also clears so a pattern's busy wait never inherits the previous
  // pattern's count (or a stale count from an earlier run).
  assign w_wd_clr = (r_state == ST_ISSUE) || (r_state == ST_FETCH);
  assign w_wd_cnt = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_VALID);

  set_drv_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wd_clr),
    .i_cnt_en (w_wd_cnt),
    .o_expired(w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  // Case-inequality so an X/Z candidate is a mismatch in simulation.
  assign w_mismatch = r_tmo_hit | (r_cand !== r_exp);
  assign w_err_nxt  = w_mismatch ? sat_inc7(r_err) : r_err;
  assign w_stop     = (w_err_nxt == ERR_LIM) || (r_idx == LAST_IDX);

  assign pat_addr = r_addr;
  assign en       = r_en;
  assign central  = r_central;
  assign radius   = r_radius;
  assign mode     = r_mode;
  assign done     = r_done;
  assign pass     = r_pass;
  assign err_cnt  = r_err;
  assign fail_idx = r_fidx;

  // Run sequencer: fetch, issue, collect and score one pattern at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_ph <= 1'b0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_pat_c    <= '0;
      r_pat_r    <= '0;
      r_exp      <= '0;
      r_cand     <= '0;
      r_tmo_hit  <= 1'b0;
      r_en       <= 1'b0;
      r_central  <= '0;
      r_radius   <= '0;
      r_mode     <= MODE_SINGLE;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_fidx     <= '0;
    end else begin
      r_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_err      <= '0;
            r_fidx     <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_mode     <= mode_cfg;
            r_fetch_ph <= 1'b0;
            r_tmo_hit  <= 1'b0;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!r_fetch_ph) begin
            r_fetch_ph <= 1'b1;
          end else begin
            r_fetch_ph <= 1'b0;
            r_pat_c    <= pat_central;
            r_pat_r    <= pat_radius;
            r_exp      <= exp_cand;
            r_state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!busy) begin
            r_en      <= 1'b1;
            r_central <= r_pat_c;
            r_radius  <= r_pat_r;
            r_state   <= ST_ISSUE;
          end else if (w_tmo) begin
            r_tmo_hit <= 1'b1;
            r_state   <= ST_CHECK;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_VALID;
        end
        ST_WAIT_VALID: begin
          if (valid) begin
            r_cand  <= candidate;
            r_state <= ST_CHECK;
          end else if (w_tmo) begin
            r_tmo_hit <= 1'b1;
            r_state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_err     <= w_err_nxt;
          r_tmo_hit <= 1'b0;
          if (w_mismatch && (r_err == 7'd0)) r_fidx <= r_idx;
          if (w_stop) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 7'd0);
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 6'd1;
            r_addr  <= r_idx + 6'd1;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_driver.sv
// tb_set_driver: ROM + behavioural SET model around set_driver; expected
// issues and run results are queued by the stimulus and checked by a monitor.
module tb_set_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode_cfg = 2'b00;
  logic [5:0]  pat_addr;
  logic [23:0] pat_central;
  logic [11:0] pat_radius;
  logic [7:0]  exp_cand;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;
  logic        done;
  logic        pass;
  logic [6:0]  err_cnt;
  logic [5:0]  fail_idx;

  set_driver #(.NUM_PAT(64), .ERR_LIMIT(10), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_cfg(mode_cfg),
    .pat_addr(pat_addr), .pat_central(pat_central), .pat_radius(pat_radius),
    .exp_cand(exp_cand), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate),
    .done(done), .pass(pass), .err_cnt(err_cnt), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] rom_c [64];
  logic [11:0] rom_r [64];
  logic [7:0]  rom_e [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_c[i] = 24'((i + 1) * 24'h0A3C5F) ^ 24'h5A5A5A;
      rom_r[i] = 12'(i * 12'h1D3) + 12'h101;
      rom_e[i] = 8'(i * 37 + 11);
    end
  end

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) begin
    pat_central <= rom_c[pat_addr];
    pat_radius  <= rom_r[pat_addr];
    exp_cand    <= rom_e[pat_addr];
  end

  typedef struct { logic [23:0] c; logic [11:0] r; logic [1:0] m; bit be; } en_exp_t;
  typedef struct { bit p; logic [6:0] e; logic [5:0] f; int n; } done_exp_t;
  en_exp_t   en_q[$];
  done_exp_t done_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // SET model knobs
  int          lat = 2;
  int          busy_hold = 0;
  int          no_valid = -1;
  int          m_idx = 0;
  logic [63:0] bad_mask = '0;

  // Behavioural SET: answers each en with rom_e (or a corrupted value).
  initial begin
    busy = 1'b0; valid = 1'b0; candidate = 8'h00;
    forever begin
      @(negedge clk);
      if (en === 1'b1) begin
        int k;
        logic [7:0] cv;
        k = m_idx;
        m_idx++;
        cv = rom_e[k[5:0]] ^ (bad_mask[k[5:0]] ? 8'hFF : 8'h00);
        repeat (lat - 1) @(negedge clk);
        if (k != no_valid) begin
          valid = 1'b1; candidate = cv;
          @(negedge clk);
          valid = 1'b0; candidate = 8'h00;
        end
        if (busy_hold > 0) begin
          busy = 1'b1;
          repeat (busy_hold) @(negedge clk);
          busy = 1'b0;
        end
      end
    end
  end

  // Monitor: checks every en pulse and every done rising edge.
  initial begin
    bit pen, pb, pd;
    int n_en;
    en_exp_t ee;
    done_exp_t de;
    pen = 0; pb = 0; pd = 0; n_en = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        n_en = 0;
      end else begin
        if (en) begin
          n_en++;
          if (en_q.size() == 0) flag("en_unexpected");
          else begin
            ee = en_q.pop_front();
            chk("en_central", 64'(central), 64'(ee.c));
            chk("en_radius", 64'(radius), 64'(ee.r));
            chk("en_mode", 64'(mode), 64'(ee.m));
            chk("en_onecycle_notbusy", 64'({pen, busy}), 64'(0));
            if (ee.be) chk("en_after_busy_fall", 64'(pb), 64'(1));
          end
        end
        if (done && !pd) begin
          if (done_q.size() == 0) flag("done_unexpected");
          else begin
            de = done_q.pop_front();
            chk("done_pass", 64'(pass), 64'(de.p));
            chk("done_err_cnt", 64'(err_cnt), 64'(de.e));
            chk("done_fail_idx", 64'(fail_idx), 64'(de.f));
            chk("done_en_count", 64'(n_en), 64'(de.n));
          end
          n_en = 0;
        end
      end
      pen = en; pb = busy; pd = done;
    end
  end

  task automatic push_en(input int n, input logic [1:0] m, input bit bh);
    en_exp_t ee;
    for (int i = 0; i < n; i++) begin
      ee.c = rom_c[i]; ee.r = rom_r[i]; ee.m = m; ee.be = bh && (i > 0);
      en_q.push_back(ee);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode_cfg = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode_cfg = ~m;
    chk("first_pat_addr", 64'(pat_addr), 64'(0));
  endtask

  task automatic run(input logic [1:0] m, input logic [63:0] bad, input int bh,
                     input bit poke, input int n, input bit p,
                     input logic [6:0] e, input logic [5:0] f);
    done_exp_t de;
    bit got;
    push_en(n, m, bh > 0);
    de.p = p; de.e = e; de.f = f; de.n = n;
    done_q.push_back(de);
    bad_mask = bad; busy_hold = bh; m_idx = 0;
    pulse_start(m);
    if (poke) begin
      repeat (50) @(negedge clk);
      mode_cfg = ~m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    if (!got) begin
      flag("done_timeout");
      en_q.delete(); done_q.delete();
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({en, done, pass, err_cnt, fail_idx, pat_addr, central, radius, mode}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all patterns correct
    run(2'b01, 64'd0, 0, 0, 64, 1, 7'd0, 6'd0);
    // wrong on 5 and 9; a start mid-run must be ignored
    run(2'b10, (64'd1 << 5) | (64'd1 << 9), 0, 1, 64, 0, 7'd2, 6'd5);
    // wrong everywhere: stops at the error limit
    lat = 5;
    run(2'b11, {64{1'b1}}, 0, 0, 10, 0, 7'd10, 6'd0);
    lat = 2;
    // busy held 20 cycles after each result
    run(2'b00, 64'd0, 20, 0, 64, 1, 7'd0, 6'd0);

    // reset while waiting for pattern 30's result
    push_en(31, 2'b01, 0);
    bad_mask = '0; busy_hold = 0; m_idx = 0; no_valid = 30;
    pulse_start(2'b01);
    got = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (m_idx == 31) begin got = 1; break; end
    end
    if (!got) begin flag("reach_pat30_timeout"); en_q.delete(); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrun_reset_outs", 64'({en, done, pass, err_cnt, fail_idx, pat_addr, central, radius, mode}), 64'(0));
    repeat (3) @(negedge clk);
    chk("held_reset_outs", 64'({en, done, pass, err_cnt, fail_idx, pat_addr, central, radius, mode}), 64'(0));
    rst = 1'b0;
    no_valid = -1;
    repeat (5) @(negedge clk);
    run(2'b10, 64'd0, 0, 0, 64, 1, 7'd0, 6'd0);

`ifdef SET_DRV_TIMEOUT_EN
    // pattern 3 never answers: watchdog logs it and the run continues
    no_valid = 3;
    run(2'b01, 64'd0, 0, 0, 64, 0, 7'd1, 6'd3);
    no_valid = -1;
`endif

    chk("queues_drained", 64'(en_q.size() + done_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
